// File: rtl/sprite_line_fetcher.sv
// Per-scanline sprite fetch engine: scans the attribute table, streams each hit sprite's
// row out of the pattern ROM and writes opaque, on-screen pixels into the line buffer.
module sprite_line_fetcher #(
    parameter int          NUM_SPRITES = 8,
    parameter int          LINE_WIDTH  = 640,
    parameter logic [7:0]  TRANSPARENT = 8'h00,
    localparam int         IDX_W       = $clog2(NUM_SPRITES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             attr_we,
    input  logic [IDX_W-1:0] attr_index,
    input  logic [31:0]      attr_data,
    input  logic             line_start,
    input  logic [9:0]       line_num,
    output logic             busy,
    output logic             done,
    output logic [11:0]      rom_address,
    output logic             rom_clken,
    input  logic [7:0]       rom_readdata,
    output logic             lb_we,
    output logic [9:0]       lb_addr,
    output logic [7:0]       lb_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FETCH,
        S_DRAIN,
        S_FINISH
    } state_e;

    // Attribute table
    logic [NUM_SPRITES-1:0] en_q;
    logic [3:0]             pat_tab_q [NUM_SPRITES];
    logic [9:0]             x_tab_q   [NUM_SPRITES];
    logic [9:0]             y_tab_q   [NUM_SPRITES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q <= '0;
        end else if (attr_we) begin
            en_q[attr_index] <= attr_data[31];
        end
    end

    // NOTE: the field storage has no reset; a cleared enable is enough to make a slot inert.
    always_ff @(posedge clk) begin
        if (attr_we) begin
            pat_tab_q[attr_index] <= attr_data[27:24];
            x_tab_q[attr_index]   <= attr_data[19:10];
            y_tab_q[attr_index]   <= attr_data[9:0];
        end
    end

    // Sequencer and working registers
    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [9:0]       line_q;
    logic [3:0]       col_q;
    logic [3:0]       pat_w_q;
    logic [9:0]       x_w_q;
    logic [3:0]       row_q;
    logic             busy_q;
    logic             done_q;
    logic             rom_clken_q;
    logic [11:0]      rom_addr_q;

    // Write pipeline: stage 1 holds the pixel position while the ROM word is in flight
    logic             s1_valid_q;
    logic [10:0]      s1_px_q;
    logic             lb_we_q;
    logic [9:0]       lb_addr_q;
    logic [7:0]       lb_data_q;

    logic [9:0] row_d;
    logic       hit_d;
    logic       last_slot;

    // Modular row; the explicit line >= y test rejects sprites that start below this line
    assign row_d     = line_q - y_tab_q[idx_q];
    assign hit_d     = en_q[idx_q] && (line_q >= y_tab_q[idx_q]) && (row_d < 10'd16);
    assign last_slot = (idx_q == IDX_W'(NUM_SPRITES - 1));

    // NOTE: every register here is updated with non-blocking assignments so all stages
    // see the previous cycle's values, which is what makes the pipeline timing exact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            line_q      <= '0;
            col_q       <= '0;
            pat_w_q     <= '0;
            x_w_q       <= '0;
            row_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rom_clken_q <= 1'b0;
            rom_addr_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_px_q     <= '0;
            lb_we_q     <= 1'b0;
            lb_addr_q   <= '0;
            lb_data_q   <= '0;
        end else begin
            done_q     <= 1'b0;

            s1_valid_q <= (state_q == S_FETCH);
            s1_px_q    <= {1'b0, x_w_q} + {7'd0, col_q};
            lb_we_q    <= s1_valid_q && (rom_readdata != TRANSPARENT)
                          && (s1_px_q < 11'(LINE_WIDTH));
            if (s1_valid_q) begin
                lb_addr_q <= s1_px_q[9:0];
                lb_data_q <= rom_readdata;
            end

            case (state_q)
                S_IDLE: begin
                    if (line_start) begin
                        line_q  <= line_num;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (hit_d) begin
                        pat_w_q     <= pat_tab_q[idx_q];
                        x_w_q       <= x_tab_q[idx_q];
                        row_q       <= row_d[3:0];
                        col_q       <= '0;
                        rom_addr_q  <= {pat_tab_q[idx_q], row_d[3:0], 4'd0};
                        rom_clken_q <= 1'b1;
                        state_q     <= S_FETCH;
                    end else if (last_slot) begin
                        state_q <= S_FINISH;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_FETCH: begin
                    if (col_q == 4'd15) begin
                        rom_clken_q <= 1'b0;
                        state_q     <= S_DRAIN;
                    end else begin
                        col_q      <= col_q + 4'd1;
                        rom_addr_q <= {pat_w_q, row_q, col_q + 4'd1};
                    end
                end
                S_DRAIN: begin
                    if (last_slot) begin
                        state_q <= S_FINISH;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= S_CHECK;
                    end
                end
                S_FINISH: begin
                    if (!s1_valid_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign rom_address = rom_addr_q;
    assign rom_clken   = rom_clken_q;
    assign lb_we       = lb_we_q;
    assign lb_addr     = lb_addr_q;
    assign lb_data     = lb_data_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Scoreboard bench for sprite_line_fetcher: a per-line reference model predicts ROM reads,
// line-buffer writes and done timing; an independent monitor compares what the DUT emits.
module tb_sprite_line_fetcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        attr_we;
    logic [2:0]  attr_index;
    logic [31:0] attr_data;
    logic        line_start;
    logic [9:0]  line_num;
    logic        busy;
    logic        done;
    logic [11:0] rom_address;
    logic        rom_clken;
    logic [7:0]  rom_readdata;
    logic        lb_we;
    logic [9:0]  lb_addr;
    logic [7:0]  lb_data;

    sprite_line_fetcher dut (
        .clk          (clk),
        .reset        (reset),
        .attr_we      (attr_we),
        .attr_index   (attr_index),
        .attr_data    (attr_data),
        .line_start   (line_start),
        .line_num     (line_num),
        .busy         (busy),
        .done         (done),
        .rom_address  (rom_address),
        .rom_clken    (rom_clken),
        .rom_readdata (rom_readdata),
        .lb_we        (lb_we),
        .lb_addr      (lb_addr),
        .lb_data      (lb_data)
    );

    always #5 clk = ~clk;

    // Pattern ROM with one cycle of read latency
    logic [7:0] rom_mem [4096];
    always @(posedge clk) begin
        if (rom_clken) rom_readdata <= rom_mem[rom_address];
    end

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int cyc;  int busy; } done_t;

    bit    en_m  [8];
    int    pat_m [8];
    int    x_m   [8];
    int    y_m   [8];

    wr_t   lbq[$];
    int    romq[$];
    done_t doneq[$];

    int checks    = 0;
    int fails     = 0;
    int cyc       = 0;
    int done_cnt  = 0;
    int busy_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one line, sprites in ascending slot order, 16 columns each
    task automatic build_expect(input int line, output int hits);
        hits = 0;
        for (int s = 0; s < 8; s++) begin
            if (en_m[s] && line >= y_m[s] && (line - y_m[s]) < 16) begin
                int row;
                row = line - y_m[s];
                hits++;
                for (int c = 0; c < 16; c++) begin
                    int a;
                    int px;
                    a  = pat_m[s] * 256 + row * 16 + c;
                    px = x_m[s] + c;
                    romq.push_back(a);
                    if (rom_mem[a] != 8'h00 && px < 640) lbq.push_back('{px, int'(rom_mem[a])});
                end
            end
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents something
    wr_t   mw;
    done_t md;
    int    mr;
    always @(negedge clk) begin
        if (reset) begin
            busy_seen = 0;
        end else begin
            if (rom_clken) begin
                if (romq.size() == 0) check("rom_clken_unexpected", rom_clken, 0);
                else begin
                    mr = romq.pop_front();
                    check("rom_address", rom_address, mr);
                end
            end
            if (lb_we) begin
                if (lbq.size() == 0) check("lb_we_unexpected", lb_we, 0);
                else begin
                    mw = lbq.pop_front();
                    check("lb_addr", lb_addr, mw.addr);
                    check("lb_data", lb_data, mw.data);
                end
            end
            if (busy) busy_seen++;
            if (done) begin
                if (doneq.size() == 0) check("done_unexpected", done, 0);
                else begin
                    md = doneq.pop_front();
                    check("done_cycle", cyc, md.cyc);
                    check("busy_cycles", busy_seen, md.busy);
                    check("busy_at_done", busy, 0);
                    check("writes_left_at_done", lbq.size(), 0);
                end
                busy_seen = 0;
                done_cnt++;
            end
        end
    end

    task automatic write_attr(input int s, input bit en, input int pat, input int x, input int y);
        @(negedge clk);
        attr_we    = 1'b1;
        attr_index = 3'(s);
        attr_data  = {en, 3'($urandom), 4'(pat), 4'($urandom), 10'(x), 10'(y)};
        en_m[s]  = en;
        pat_m[s] = pat;
        x_m[s]   = x;
        y_m[s]   = y;
        @(negedge clk);
        attr_we = 1'b0;
    endtask

    task automatic start_line(input int line, input bit extra_pulse);
        int h;
        build_expect(line, h);
        @(negedge clk);
        doneq.push_back('{cyc + 10 + 17 * h, 9 + 17 * h});
        line_num   = 10'(line);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        if (extra_pulse) begin
            repeat (2) @(negedge clk);
            line_num   = 10'(line + 1);
            line_start = 1'b1;
            @(negedge clk);
            line_start = 1'b0;
        end
    endtask

    task automatic run_line(input int line, input bit extra_pulse);
        int d0;
        int i;
        d0 = done_cnt;
        start_line(line, extra_pulse);
        i = 0;
        while (done_cnt == d0 && i < 1000) begin
            @(posedge clk);
            i++;
        end
        check("done_seen", done_cnt - d0, 1);
        check("rom_reads_left", romq.size(), 0);
        if (done_cnt == d0) begin
            lbq.delete();
            romq.delete();
            doneq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int d0;
        bit found;
        int line;

        reset      = 1'b1;
        attr_we    = 1'b0;
        attr_index = '0;
        attr_data  = '0;
        line_start = 1'b0;
        line_num   = '0;
        for (int i = 0; i < 4096; i++) rom_mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        for (int s = 0; s < 8; s++) begin
            en_m[s] = 1'b0; pat_m[s] = 0; x_m[s] = 0; y_m[s] = 0;
        end

        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rom_clken", rom_clken, 0);
        check("rst_rom_address", rom_address, 0);
        check("rst_lb_we", lb_we, 0);
        check("rst_lb_addr", lb_addr, 0);
        check("rst_lb_data", lb_data, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Empty table: done 10 cycles after line_start
        run_line(5, 1'b0);

        // Single sprite, fully opaque row; a second line_start while busy is ignored
        for (int c = 0; c < 16; c++) rom_mem[12'h250 + c] = 8'(c + 1);
        write_attr(0, 1'b1, 2, 100, 10);
        run_line(15, 1'b1);

        // Transparent pixels are skipped
        rom_mem[12'h252] = 8'h00;
        rom_mem[12'h255] = 8'h00;
        run_line(15, 1'b0);

        // Right-edge clipping
        write_attr(0, 1'b0, 2, 100, 10);
        for (int c = 0; c < 16; c++) rom_mem[3 * 256 + 3 * 16 + c] = 8'(8'h20 + c);
        write_attr(1, 1'b1, 3, 630, 0);
        run_line(3, 1'b0);

        // Overlapping sprites: lower slot is written first
        write_attr(1, 1'b0, 3, 630, 0);
        for (int c = 0; c < 16; c++) begin
            rom_mem[12'h400 + c] = 8'(8'h40 + c);
            rom_mem[12'h500 + c] = 8'(8'h50 + c);
        end
        write_attr(2, 1'b1, 4, 50, 0);
        write_attr(5, 1'b1, 5, 50, 0);
        run_line(0, 1'b0);

        // Misses: sprite starts below the line, and wrapped y values
        write_attr(2, 1'b0, 4, 50, 0);
        write_attr(5, 1'b0, 5, 50, 0);
        write_attr(0, 1'b1, 1, 200, 11);
        run_line(10, 1'b0);
        write_attr(0, 1'b1, 1, 200, 1020);
        run_line(10, 1'b0);
        write_attr(0, 1'b1, 1, 200, 1015);
        run_line(0, 1'b0);

        // Reset in the middle of a fetch aborts the line
        rom_mem[12'h252] = 8'h33;
        write_attr(0, 1'b1, 2, 100, 10);
        d0 = done_cnt;
        start_line(15, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (lb_we) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_fetch_write_seen", found, 1);
        #1 reset = 1'b1;
        #1;
        check("abort_lb_we", lb_we, 0);
        check("abort_busy", busy, 0);
        check("abort_rom_clken", rom_clken, 0);
        lbq.delete();
        romq.delete();
        doneq.delete();
        for (int s = 0; s < 8; s++) en_m[s] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("no_done_after_abort", done_cnt - d0, 0);

        // Normal operation after the abort
        write_attr(0, 1'b1, 2, 100, 10);
        write_attr(3, 1'b1, 7, 620, 14);
        run_line(15, 1'b0);

        // Randomized lines
        for (int n = 0; n < 20; n++) begin
            line = int'($urandom_range(0, 1023));
            for (int s = 0; s < 8; s++)
                write_attr(s, $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                           int'($urandom_range(0, 1023)),
                           (line + 1024 - int'($urandom_range(0, 24))) % 1024);
            run_line(line, $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/sprite_line_fetcher.md
Name: sprite_line_fetcher

Overview:
- Per-scanline sprite fetch engine. Sits directly downstream of the 4096x8 sprite pattern ROM (16 patterns of 16x16 8-bit pixels, 1-cycle read latency).
- On each line_start it scans an internal attribute table and fetches the visible row of every sprite that hits the line. It writes the opaque pixels into the downstream scanline buffer during horizontal blanking.

Parameters:
- NUM_SPRITES, 8, number of attribute slots (index width 3).
- LINE_WIDTH, 640, visible pixels per line; writes at x >= LINE_WIDTH are suppressed.
- TRANSPARENT, 8'h00, pixel value that is never written.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- attr_we  in  1  attribute table write strobe.
- attr_index  in  3  slot being written.
- attr_data  in  32  slot contents: [31] enable, [27:24] pattern, [19:10] x, [9:0] y; other bits ignored.
- line_start  in  1  single-cycle request to build a line.
- line_num  in  10  line to build; sampled with line_start.
- busy  out  1  high from the cycle after an accepted line_start until done.
- done  out  1  one-cycle pulse when the line is complete.
- rom_address  out  12  ROM address = {pattern, row[3:0], col[3:0]}.
- rom_clken  out  1  ROM clock enable; high only in FETCH.
- rom_readdata  in  8  ROM data; valid the cycle after the address is presented with rom_clken=1.
- lb_we  out  1  line buffer write enable.
- lb_addr  out  10  line buffer pixel address.
- lb_data  out  8  pixel value.

Behaviour:
- Reset (async): FSM to IDLE; all attribute enables cleared; busy, done, rom_clken, lb_we = 0; rom_address, lb_addr, lb_data = 0.
- Attribute table: a write updates the slot at the next edge, in any state. Each sprite's fields are latched into working registers in its CHECK cycle, so a write during FETCH of that sprite takes effect from the next line.
- FSM states: IDLE, CHECK, FETCH, DRAIN, FINISH.
- IDLE:
  - line_start=1: latch line_num, set idx=0, go to CHECK, set busy=1.
  - line_start while busy: ignored.
- CHECK (1 cycle per slot):
  - Compute row = line_num - y (10-bit).
  - Hit = enable && line_num >= y && row < 16.
  - Hit: col=0, go to FETCH.
  - Miss: if idx == NUM_SPRITES-1 go to FINISH, else idx+1 and stay in CHECK.
- FETCH (16 cycles):
  - Each cycle drive rom_address={pattern,row[3:0],col}, rom_clken=1, col+1.
  - After col 15 go to DRAIN.
- DRAIN (1 cycle): rom_clken=0; the last ROM word returns. Then next CHECK (idx+1), or FINISH if idx is the last slot.
- Write pipeline:
  - The address presented in cycle t returns in t+1.
  - In t+1 form px = x + col as an 11-bit sum.
  - The registered write appears in t+2: lb_we=1 iff rom_readdata != TRANSPARENT && px < LINE_WIDTH; lb_addr=px[9:0]; lb_data=rom_readdata.
  - Suppressed pixels give lb_we=0 and no write.
- Priority: slots are processed in ascending index, so a higher index overwrites a lower one (higher index is on top). Overlapping pixels are simply written twice.
- FINISH:
  - Wait until the write pipeline holds no valid entries.
  - Then assert done=1 for one cycle with busy=0 in that same cycle, and return to IDLE.
  - done never precedes the final lb_we.
  - A line_start in the done cycle is accepted.
- Latency:
  - line with h hit sprites: 1 + NUM_SPRITES + 17*h + pipeline drain cycles.
  - NUM_SPRITES=8, h=0: done exactly 10 cycles after line_start.
- Row wrap: y > line_num gives a large unsigned row and is treated as a miss. y in 1009..1023 never hits line 0.
- The block never drives a ROM write; the ROM is used read-only.
- Reset mid-operation: aborts immediately. No further lb_we and no done pulse.

Test Plan:
- Reset, then line_start line_num=5 with all slots disabled -> no rom_clken, no lb_we, done exactly 10 cycles later, busy high for the 9 cycles between.
- Slot0 = {en=1, pattern=2, x=100, y=10}, ROM preloaded with bytes 1..16 at 0x250..0x25F, line_num=15 -> rom_address 0x250..0x25F over 16 consecutive cycles; lb writes to addresses 100..115 with data 1..16.
- Same slot, but ROM bytes 0x252 and 0x255 = 0x00 -> exactly 14 writes; addresses 102 and 105 are absent.
- Slot1 x=630, y=0, line_num=3, all 16 bytes opaque -> writes only to 630..639; no lb_we for px 640..645.
- Slot2 and slot5 both at x=50, y=0, different patterns, line_num=0 -> slot2's 16 writes all precede slot5's 16 writes at addresses 50..65.
- Assert reset mid-FETCH -> lb_we=0 and busy=0 immediately, no done pulse. A subsequent line_start with slots re-written completes normally.
- Extra checks: line_num=10 with y=11 is a miss; line_num=10 with y=1020 is a miss.
